// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: drives the program counter, the instruction fetch
// handshake, and next-PC selection (increment, branch, halt).
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start             begin fetching (only in IDLE and HALT)
//   imem_req/addr     fetch request and address (addr is pc)
//   imem_ack/rdata    fetch acknowledge and instruction data
//   instr/instr_valid latched instruction and one-cycle update pulse
//   ex_done           execute finished (only in EXEC)
//   branch_taken      take branch_target as the next pc
//   branch_target     branch destination
//   halt_req          halt instead of advancing
//   pc/pc_inc         current pc and (pc+1) mod 2^PC_W
//   wrap              pulse when pc steps from all-ones to zero
//   halted            high while in HALT
//   retire_cnt        saturating retired-instruction count
//   state             IDLE=0 FETCH=1 EXEC=2 HALT=3
module pc_fetch_sequencer #(
   parameter int PC_W     = 3,
   parameter int IW       = 8,
   parameter int RESET_PC = 0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [IW-1:0]   imem_rdata,
   output logic [IW-1:0]   instr,
   output logic            instr_valid,
   input  logic            ex_done,
   input  logic            branch_taken,
   input  logic [PC_W-1:0] branch_target,
   input  logic            halt_req,
   output logic [PC_W-1:0] pc,
   output logic [PC_W-1:0] pc_inc,
   output logic            wrap,
   output logic            halted,
   output logic [7:0]      retire_cnt,
   output logic [1:0]      state
);

   localparam logic [PC_W-1:0] LP_RST_PC = PC_W'(RESET_PC);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_EXEC  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] w_pc_nxt;
   logic [PC_W-1:0] w_pc_inc;
   logic            r_req;
   logic            w_req_nxt;
   logic [IW-1:0]   r_instr;
   logic [IW-1:0]   w_instr_nxt;
   logic            r_iv;
   logic            w_iv_nxt;
   logic            r_wrap;
   logic            w_wrap_nxt;
   logic            r_halted;
   logic            w_halted_nxt;
   logic [7:0]      r_cnt;
   logic [7:0]      w_cnt_nxt;

   assign w_pc_inc = r_pc + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_req_nxt    = 1'b0;
      w_instr_nxt  = r_instr;
      w_iv_nxt     = 1'b0;
      w_wrap_nxt   = 1'b0;
      w_halted_nxt = r_halted;
      w_cnt_nxt    = r_cnt;
      unique case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_FETCH;
            end
         end
         S_FETCH: begin
            // The ack only counts once the request is visible to memory;
            // the request is raised one cycle after entering FETCH.
            if (r_req && imem_ack) begin
               w_instr_nxt = imem_rdata;
               w_iv_nxt    = 1'b1;
               w_state_nxt = S_EXEC;
            end else begin
               w_req_nxt   = 1'b1;
            end
         end
         S_EXEC: begin
            if (ex_done) begin
               if (r_cnt != 8'hFF) begin
                  w_cnt_nxt = r_cnt + 8'd1;
               end
               if (halt_req) begin
                  w_state_nxt  = S_HALT;
                  w_halted_nxt = 1'b1;
               end else if (branch_taken) begin
                  w_pc_nxt    = branch_target;
                  w_state_nxt = S_FETCH;
               end else begin
                  w_pc_nxt    = w_pc_inc;
                  w_wrap_nxt  = (r_pc == '1);
                  w_state_nxt = S_FETCH;
               end
            end
         end
         S_HALT: begin
            if (start) begin
               w_pc_nxt     = LP_RST_PC;
               w_halted_nxt = 1'b0;
               w_state_nxt  = S_FETCH;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc     <= LP_RST_PC;
         r_req    <= 1'b0;
         r_instr  <= '0;
         r_iv     <= 1'b0;
         r_wrap   <= 1'b0;
         r_halted <= 1'b0;
         r_cnt    <= 8'd0;
      end else begin
         r_pc     <= w_pc_nxt;
         r_req    <= w_req_nxt;
         r_instr  <= w_instr_nxt;
         r_iv     <= w_iv_nxt;
         r_wrap   <= w_wrap_nxt;
         r_halted <= w_halted_nxt;
         r_cnt    <= w_cnt_nxt;
      end
   end

   assign imem_req    = r_req;
   assign imem_addr   = r_pc;
   assign instr       = r_instr;
   assign instr_valid = r_iv;
   assign pc          = r_pc;
   assign pc_inc      = w_pc_inc;
   assign wrap        = r_wrap;
   assign halted      = r_halted;
   assign retire_cnt  = r_cnt;
   assign state       = r_state;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: directed scenarios for pc_fetch_sequencer
// with hand-computed expected values.
module tb_pc_fetch_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       imem_req;
   logic [2:0] imem_addr;
   logic       imem_ack = 1'b0;
   logic [7:0] imem_rdata = 8'h00;
   logic [7:0] instr;
   logic       instr_valid;
   logic       ex_done = 1'b0;
   logic       branch_taken = 1'b0;
   logic [2:0] branch_target = 3'd0;
   logic       halt_req = 1'b0;
   logic [2:0] pc;
   logic [2:0] pc_inc;
   logic       wrap;
   logic       halted;
   logic [7:0] retire_cnt;
   logic [1:0] state;

   int n_checks = 0;
   int n_fail   = 0;

   pc_fetch_sequencer #(.PC_W(3), .IW(8), .RESET_PC(0)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .ex_done       (ex_done),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .halt_req      (halt_req),
      .pc            (pc),
      .pc_inc        (pc_inc),
      .wrap          (wrap),
      .halted        (halted),
      .retire_cnt    (retire_cnt),
      .state         (state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Wait (bounded) for the request, then ack it one cycle later.
   // Returns in the cycle where instr_valid should be high.
   task automatic do_fetch(input logic [7:0] d,
                           output logic [2:0] a,
                           output bit to);
      int n;
      n  = 0;
      to = 1'b0;
      while (imem_req !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      if (imem_req !== 1'b1) to = 1'b1;
      a = imem_addr;
      tick();
      imem_ack   = 1'b1;
      imem_rdata = d;
      tick();
      imem_ack   = 1'b0;
   endtask

   // ex_done two cycles after instr_valid; w = wrap after that edge.
   task automatic do_exec(input logic br, input logic [2:0] tgt,
                          input logic hlt, output logic w);
      tick();
      tick();
      ex_done       = 1'b1;
      branch_taken  = br;
      branch_target = tgt;
      halt_req      = hlt;
      tick();
      ex_done       = 1'b0;
      branch_taken  = 1'b0;
      halt_req      = 1'b0;
      w = wrap;
   endtask

   task automatic wait_req(output bit to);
      int n;
      n  = 0;
      to = 1'b0;
      while (imem_req !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      if (imem_req !== 1'b1) to = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({state, pc, imem_req, instr, instr_valid, wrap, halted,
           retire_cnt} !== 23'd0) begin
         n_fail++;
         $display("FAIL reset_state: st=%0d pc=%0d req=%b instr=%h iv=%b wrap=%b hlt=%b cnt=%0d, need all 0",
                  state, pc, imem_req, instr, instr_valid, wrap,
                  halted, retire_cnt);
      end
      n_checks++;
      if (pc_inc !== 3'd1) begin
         n_fail++;
         $display("FAIL reset_pc_inc: got %0d need 1", pc_inc);
      end
   endtask

   task automatic test_sequential();
      logic [2:0] a;
      logic       w;
      bit         to;
      int         wraps;
      wraps = 0;
      do_start();
      n_checks++;
      if (state !== 2'd1 || imem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL seq_enter_fetch: st=%0d req=%b need 1/0",
                  state, imem_req);
      end
      for (int i = 0; i < 8; i++) begin
         do_fetch(8'h10 + 8'(i), a, to);
         n_checks++;
         if (to || a !== 3'(i)) begin
            n_fail++;
            $display("FAIL seq_addr%0d: got %0d to=%0d need %0d",
                     i, a, to, i);
         end
         do_exec(1'b0, 3'd0, 1'b0, w);
         if (w === 1'b1) wraps++;
         n_checks++;
         if (w !== (i == 7)) begin
            n_fail++;
            $display("FAIL seq_wrap%0d: got %b need %b", i, w, i == 7);
         end
      end
      wait_req(to);
      n_checks++;
      if (to || imem_addr !== 3'd0 || wraps != 1) begin
         n_fail++;
         $display("FAIL seq_final: addr=%0d to=%0d wraps=%0d need 0/0/1",
                  imem_addr, to, wraps);
      end
      n_checks++;
      if (retire_cnt !== 8'd8) begin
         n_fail++;
         $display("FAIL seq_retire: got %0d need 8", retire_cnt);
      end
   endtask

   task automatic test_branch();
      logic [2:0] a;
      logic       w;
      bit         to;
      for (int i = 0; i < 5; i++) begin
         do_fetch(8'h20, a, to);
         do_exec(1'b0, 3'd0, 1'b0, w);
      end
      n_checks++;
      if (pc !== 3'd5 || retire_cnt !== 8'd13) begin
         n_fail++;
         $display("FAIL br_setup: pc=%0d cnt=%0d need 5/13",
                  pc, retire_cnt);
      end
      do_fetch(8'h21, a, to);
      do_exec(1'b1, 3'd2, 1'b0, w);
      n_checks++;
      if (w !== 1'b0 || pc !== 3'd2 || state !== 2'd1) begin
         n_fail++;
         $display("FAIL br_take: wrap=%b pc=%0d st=%0d need 0/2/1",
                  w, pc, state);
      end
      wait_req(to);
      n_checks++;
      if (to || imem_addr !== 3'd2 || retire_cnt !== 8'd14) begin
         n_fail++;
         $display("FAIL br_fetch: addr=%0d cnt=%0d to=%0d need 2/14/0",
                  imem_addr, retire_cnt, to);
      end
   endtask

   task automatic test_halt();
      logic [2:0] a;
      logic       w;
      bit         to;
      do_fetch(8'h30, a, to);
      do_exec(1'b0, 3'd0, 1'b0, w);
      do_fetch(8'h31, a, to);
      n_checks++;
      if (a !== 3'd3) begin
         n_fail++;
         $display("FAIL halt_setup: addr=%0d need 3", a);
      end
      do_exec(1'b1, 3'd6, 1'b1, w);
      tick();
      tick();
      n_checks++;
      if (state !== 2'd3 || halted !== 1'b1 || pc !== 3'd3 ||
          imem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL halt_hold: st=%0d hlt=%b pc=%0d req=%b need 3/1/3/0",
                  state, halted, pc, imem_req);
      end
      do_start();
      n_checks++;
      if (state !== 2'd1 || halted !== 1'b0 || pc !== 3'd0 ||
          retire_cnt !== 8'd16) begin
         n_fail++;
         $display("FAIL halt_restart: st=%0d hlt=%b pc=%0d cnt=%0d need 1/0/0/16",
                  state, halted, pc, retire_cnt);
      end
   endtask

   task automatic test_fetch_wait();
      tick();
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (imem_req !== 1'b1 || imem_addr !== 3'd0) begin
            n_fail++;
            $display("FAIL wait_hold%0d: req=%b addr=%0d need 1/0",
                     i, imem_req, imem_addr);
         end
         tick();
      end
      imem_ack   = 1'b1;
      imem_rdata = 8'hA5;
      tick();
      imem_ack   = 1'b0;
      n_checks++;
      if (instr !== 8'hA5 || instr_valid !== 1'b1 ||
          imem_req !== 1'b0 || state !== 2'd2) begin
         n_fail++;
         $display("FAIL wait_ack: instr=%h iv=%b req=%b st=%0d need a5/1/0/2",
                  instr, instr_valid, imem_req, state);
      end
      tick();
      n_checks++;
      if (instr_valid !== 1'b0 || instr !== 8'hA5) begin
         n_fail++;
         $display("FAIL wait_pulse: iv=%b instr=%h need 0/a5",
                  instr_valid, instr);
      end
   endtask

   task automatic test_ignored_inputs();
      imem_ack   = 1'b1;
      imem_rdata = 8'h3C;
      tick();
      imem_ack   = 1'b0;
      n_checks++;
      if (state !== 2'd2 || instr !== 8'hA5 || instr_valid !== 1'b0 ||
          retire_cnt !== 8'd16) begin
         n_fail++;
         $display("FAIL ign_ack: st=%0d instr=%h iv=%b cnt=%0d need 2/a5/0/16",
                  state, instr, instr_valid, retire_cnt);
      end
      ex_done = 1'b1;
      tick();
      ex_done = 1'b0;
      n_checks++;
      if (state !== 2'd1 || pc !== 3'd1 || retire_cnt !== 8'd17) begin
         n_fail++;
         $display("FAIL ign_retire: st=%0d pc=%0d cnt=%0d need 1/1/17",
                  state, pc, retire_cnt);
      end
      ex_done = 1'b1;
      start   = 1'b1;
      tick();
      ex_done = 1'b0;
      start   = 1'b0;
      n_checks++;
      if (state !== 2'd1 || pc !== 3'd1 || retire_cnt !== 8'd17) begin
         n_fail++;
         $display("FAIL ign_done: st=%0d pc=%0d cnt=%0d need 1/1/17",
                  state, pc, retire_cnt);
      end
   endtask

   task automatic test_reset_mid();
      logic [2:0] a;
      logic       w;
      bit         to;
      do_reset();
      do_start();
      do_fetch(8'h40, a, to);
      do_exec(1'b1, 3'd3, 1'b0, w);
      for (int i = 0; i < 3; i++) begin
         do_fetch(8'h41, a, to);
         do_exec(1'b0, 3'd0, 1'b0, w);
      end
      do_fetch(8'h5A, a, to);
      tick();
      n_checks++;
      if (to || state !== 2'd2 || pc !== 3'd6 || retire_cnt !== 8'd4) begin
         n_fail++;
         $display("FAIL rstm_setup: st=%0d pc=%0d cnt=%0d to=%0d need 2/6/4/0",
                  state, pc, retire_cnt, to);
      end
      do_reset();
      n_checks++;
      if ({state, pc, imem_req, instr, instr_valid, wrap, halted,
           retire_cnt} !== 23'd0 || imem_addr !== 3'd0) begin
         n_fail++;
         $display("FAIL rstm_state: st=%0d pc=%0d req=%b instr=%h cnt=%0d need all 0",
                  state, pc, imem_req, instr, retire_cnt);
      end
   endtask

   task automatic test_saturate();
      logic [2:0] a;
      logic       w;
      bit         to;
      bit         any_to;
      any_to = 1'b0;
      do_start();
      for (int i = 0; i < 300; i++) begin
         do_fetch(8'h00, a, to);
         if (to) any_to = 1'b1;
         do_exec(1'b0, 3'd0, 1'b0, w);
         if (i == 254) begin
            n_checks++;
            if (retire_cnt !== 8'd255) begin
               n_fail++;
               $display("FAIL sat_reach: got %0d need 255", retire_cnt);
            end
         end
      end
      n_checks++;
      if (any_to || retire_cnt !== 8'd255) begin
         n_fail++;
         $display("FAIL sat_hold: cnt=%0d to=%0d need 255/0",
                  retire_cnt, any_to);
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_sequential();
      test_branch();
      test_halt();
      test_fetch_wait();
      test_ignored_inputs();
      test_reset_mid();
      test_saturate();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
